// File: rtl/cv32e40x_pkg.sv
// Shared types and defaults for the register-file write-port arbiter slice.
// The arbiter's optional zero-latency path is selected with CV32E40X_RF_ARB_BYPASS_EN.
package cv32e40x_pkg;

  typedef logic [4:0] rf_addr_t;

  typedef struct packed {
    rf_addr_t    waddr;
    logic [31:0] wdata;
  } xres_entry_t;

  localparam int unsigned RF_ARB_FIFO_DEPTH = 2;

  // One-hot mask of a register index, used for scoreboard set/clear vectors.
  function automatic logic [31:0] rf_onehot(input rf_addr_t addr);
    return 32'b1 << addr;
  endfunction

endpackage

// File: rtl/cv32e40x_xres_fifo.sv
// Synchronous FIFO of coprocessor writeback entries; head is visible without popping.
// Push when full and pop when empty are ignored, so the caller may drive them freely.
module cv32e40x_xres_fifo
  import cv32e40x_pkg::*;
#(
  parameter int unsigned DEPTH = RF_ARB_FIFO_DEPTH
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_push,
  input  xres_entry_t i_data,
  input  logic        i_pop,
  output logic        o_full,
  output logic        o_empty,
  output xres_entry_t o_head
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

  xres_entry_t   r_mem [DEPTH];
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [AW:0]   r_count;
  logic          w_push_ok;
  logic          w_pop_ok;

  assign o_full    = (r_count == FULL_CNT);
  assign o_empty   = (r_count == '0);
  assign o_head    = r_mem[r_rptr];
  assign w_push_ok = i_push && !o_full;
  assign w_pop_ok  = i_pop && !o_empty;

  // DEPTH is a power of two, so the pointers wrap by natural overflow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push_ok) r_wptr <= r_wptr + 1'b1;
      if (w_pop_ok)  r_rptr <= r_rptr + 1'b1;
      r_count <= r_count + {{AW{1'b0}}, w_push_ok} - {{AW{1'b0}}, w_pop_ok};
    end
  end

  always_ff @(posedge clk) begin
    if (w_push_ok) r_mem[r_wptr] <= i_data;
  end

endmodule

// File: rtl/cv32e40x_rf_wport_arbiter.sv
// Shares the register-file write port between WB (always wins) and buffered XIF results,
// and tracks outstanding offloaded writebacks for ID hazards. Option: CV32E40X_RF_ARB_BYPASS_EN.
module cv32e40x_rf_wport_arbiter
  import cv32e40x_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = RF_ARB_FIFO_DEPTH
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        wb_we_i,
  input  logic [4:0]  wb_waddr_i,
  input  logic [31:0] wb_wdata_i,
  input  logic        xres_valid_i,
  output logic        xres_ready_o,
  input  logic        xres_we_i,
  input  logic [4:0]  xres_rd_i,
  input  logic [31:0] xres_data_i,
  input  logic        xres_exc_i,
  input  logic        sb_set_i,
  input  logic [4:0]  sb_set_addr_i,
  input  logic [4:0]  rs1_addr_i,
  input  logic [4:0]  rs2_addr_i,
  input  logic [4:0]  rd_addr_i,
  output logic        hazard_o,
  output logic        pending_o,
  output logic        xres_exc_o,
  output logic        rf_we_o,
  output logic [4:0]  rf_waddr_o,
  output logic [31:0] rf_wdata_o
);

  logic        w_full;
  logic        w_empty;
  logic        w_accept;
  logic        w_writable;
  logic        w_bypass;
  logic        w_push;
  logic        w_pop;
  xres_entry_t w_head;
  xres_entry_t w_in;
  logic [31:0] w_sb_set;
  logic [31:0] w_sb_clr;
  logic [31:0] r_sb;
  logic        r_exc;

  // Handshake: a result transfers on a cycle where xres_valid_i && xres_ready_o;
  // ready depends only on FIFO occupancy, never on xres_valid_i.
  assign xres_ready_o = !w_full;
  assign w_accept     = xres_valid_i && !w_full;
  assign w_writable   = xres_we_i && !xres_exc_i && (xres_rd_i != 5'd0);

`ifdef CV32E40X_RF_ARB_BYPASS_EN
  assign w_bypass = w_accept && w_writable && w_empty && !wb_we_i;
`else
  assign w_bypass = 1'b0;
`endif

  assign w_push     = w_accept && w_writable && !w_bypass;
  assign w_pop      = !wb_we_i && !w_empty;
  assign w_in.waddr = xres_rd_i;
  assign w_in.wdata = xres_data_i;

  cv32e40x_xres_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_push),
    .i_data  (w_in),
    .i_pop   (w_pop),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_head  (w_head)
  );

  always_comb begin
    rf_we_o    = 1'b0;
    rf_waddr_o = '0;
    rf_wdata_o = '0;
    if (wb_we_i) begin
      rf_we_o    = 1'b1;
      rf_waddr_o = wb_waddr_i;
      rf_wdata_o = wb_wdata_i;
    end else if (!w_empty) begin
      rf_we_o    = 1'b1;
      rf_waddr_o = w_head.waddr;
      rf_wdata_o = w_head.wdata;
    end else if (w_bypass) begin
      rf_we_o    = 1'b1;
      rf_waddr_o = xres_rd_i;
      rf_wdata_o = xres_data_i;
    end
  end

  // A pop and a dropped/bypassed result can clear two different bits in one cycle.
  always_comb begin
    w_sb_set = '0;
    w_sb_clr = '0;
    if (sb_set_i) w_sb_set = rf_onehot(sb_set_addr_i);
    if (w_pop) w_sb_clr = w_sb_clr | rf_onehot(w_head.waddr);
    if (w_accept && (!w_writable || w_bypass)) w_sb_clr = w_sb_clr | rf_onehot(xres_rd_i);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sb  <= '0;
      r_exc <= 1'b0;
    end else begin
      r_sb  <= ((r_sb & ~w_sb_clr) | w_sb_set) & ~32'h1;
      r_exc <= w_accept && xres_exc_i;
    end
  end

  assign hazard_o   = r_sb[rs1_addr_i] | r_sb[rs2_addr_i] | r_sb[rd_addr_i];
  assign pending_o  = (r_sb != '0) || !w_empty;
  assign xres_exc_o = r_exc;

endmodule
